obi_data_arbiter: RTL and testbench

// Shares the single data port of the TB memory (mm_ram data side) between NUM_REQ OBI

---
 rtl/obi_arb_pkg.sv | 25 ++
 rtl/obi_arb_id_fifo.sv | 69 ++++++
 rtl/obi_data_arbiter.sv | 150 +++++++++++++++
 tb/tb_obi_data_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/obi_arb_pkg.sv
// Shared types and widths for the OBI data-port arbiter.
package obi_arb_pkg;

  localparam int unsigned OBI_AW = 32;
  localparam int unsigned OBI_DW = 32;
  localparam int unsigned OBI_BW = OBI_DW / 8;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic [OBI_AW-1:0] addr;
    logic              we;
    logic [OBI_BW-1:0] be;
    logic [OBI_DW-1:0] wdata;
  } obi_req_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted, not yet answered transactions.
module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = clog2_min1(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin : next_state
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin : state_regs
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin : storage
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/obi_data_arbiter.sv
// Shares one OBI data port between NUM_REQ masters; routes in-order responses
// back to the issuing master.
module obi_data_arbiter
  import obi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter arb_mode_e   ARB_MODE        = ARB_RR,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             m_req_i,
  input  logic [NUM_REQ-1:0][OBI_AW-1:0] m_addr_i,
  input  logic [NUM_REQ-1:0]             m_we_i,
  input  logic [NUM_REQ-1:0][OBI_BW-1:0] m_be_i,
  input  logic [NUM_REQ-1:0][OBI_DW-1:0] m_wdata_i,
  output logic [NUM_REQ-1:0]             m_gnt_o,
  output logic [NUM_REQ-1:0]             m_rvalid_o,
  output logic [OBI_DW-1:0]              m_rdata_o,
  output logic                           s_req_o,
  output logic [OBI_AW-1:0]              s_addr_o,
  output logic                           s_we_o,
  output logic [OBI_BW-1:0]              s_be_o,
  output logic [OBI_DW-1:0]              s_wdata_o,
  input  logic                           s_gnt_i,
  input  logic                           s_rvalid_i,
  input  logic [OBI_DW-1:0]              s_rdata_i,
  output logic [CW-1:0]                  outstanding_o,
  output logic                           resp_err_o
);

  localparam int unsigned IW = clog2_min1(NUM_REQ);

  obi_req_t [NUM_REQ-1:0] req_s;
  obi_req_t               sel_req;

  logic          lock_q, lock_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          resp_err_q, resp_err_d;

  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [IW-1:0] sel;
  logic          fifo_full, fifo_empty;
  logic [IW-1:0] head_id;
  logic          hs, pop;

  // Candidate for search slot 'off': rotated from ptr in RR, plain index otherwise.
  function automatic logic [IW-1:0] cand_idx(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = (ARB_MODE == ARB_RR) ? 32'(base) + off : off;
    return IW'(s % NUM_REQ);
  endfunction

  always_comb begin : pack_reqs
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_s[i].addr  = m_addr_i[i];
      req_s[i].we    = m_we_i[i];
      req_s[i].be    = m_be_i[i];
      req_s[i].wdata = m_wdata_i[i];
    end
  end

  always_comb begin : arb_select
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && m_req_i[cand_idx(ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = cand_idx(ptr_q, i);
      end
    end
  end

  // A pending, ungranted address phase keeps its master selected.
  assign sel     = lock_q ? lock_idx_q : win_idx;
  assign sel_req = req_s[sel];

  assign s_req_o   = !rst_i && !fifo_full && m_req_i[sel];
  assign s_addr_o  = sel_req.addr;
  assign s_we_o    = sel_req.we;
  assign s_be_o    = sel_req.be;
  assign s_wdata_o = sel_req.wdata;

  assign hs  = s_req_o && s_gnt_i;
  assign pop = !rst_i && s_rvalid_i && !fifo_empty;

  always_comb begin : gnt_demux
    m_gnt_o = '0;
    if (hs) m_gnt_o[sel] = 1'b1;
  end

  always_comb begin : rsp_demux
    m_rvalid_o = '0;
    if (pop) m_rvalid_o[head_id] = 1'b1;
  end

  assign m_rdata_o     = s_rdata_i;
  assign resp_err_o    = resp_err_q;

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  always_comb begin : next_state
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    resp_err_d = resp_err_q;
    if (hs) begin
      lock_d = 1'b0;
      ptr_d  = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
    end else if (s_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end else if (lock_q && !m_req_i[lock_idx_q]) begin
      lock_d = 1'b0;
    end
    // A response with nothing outstanding cannot be routed.
    if (s_rvalid_i && fifo_empty) resp_err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin : state_regs
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      ptr_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Directed scoreboard bench for obi_data_arbiter (RR instance plus a FIXED instance).
module tb_obi_data_arbiter;
  import obi_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        m_req;
  logic [1:0][31:0]  m_addr;
  logic [1:0]        m_we;
  logic [1:0][3:0]   m_be;
  logic [1:0][31:0]  m_wdata;
  logic              s_gnt, s_rvalid;
  logic [31:0]       s_rdata;
  logic [1:0]        m_gnt, m_rvalid;
  logic [31:0]       m_rdata;
  logic              s_req, s_we;
  logic [31:0]       s_addr, s_wdata;
  logic [3:0]        s_be;
  logic [2:0]        outstanding;
  logic              resp_err;

  logic [1:0]        f_req;
  logic              f_gnt;
  logic [1:0]        f_m_gnt, f_m_rvalid;
  logic [31:0]       f_m_rdata, f_s_addr, f_s_wdata;
  logic              f_s_req, f_s_we, f_resp_err;
  logic [3:0]        f_s_be;
  logic [2:0]        f_outstanding;

  int errors = 0;
  int checks = 0;

  logic [1:0]  exp_gnt[$];
  logic [1:0]  exp_gnt_f[$];
  logic [1:0]  exp_rmask[$];
  logic [31:0] exp_rdata[$];

  always #5 clk = ~clk;

  obi_data_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(4), .ARB_MODE(ARB_RR)) dut (
    .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
    .m_rdata_o(m_rdata), .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we),
    .s_be_o(s_be), .s_wdata_o(s_wdata), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
    .s_rdata_i(s_rdata), .outstanding_o(outstanding), .resp_err_o(resp_err)
  );

  obi_data_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(4), .ARB_MODE(ARB_FIXED)) dut_fixed (
    .clk_i(clk), .rst_i(rst), .m_req_i(f_req), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_gnt_o(f_m_gnt), .m_rvalid_o(f_m_rvalid),
    .m_rdata_o(f_m_rdata), .s_req_o(f_s_req), .s_addr_o(f_s_addr), .s_we_o(f_s_we),
    .s_be_o(f_s_be), .s_wdata_o(f_s_wdata), .s_gnt_i(f_gnt), .s_rvalid_i(1'b0),
    .s_rdata_i(32'h0), .outstanding_o(f_outstanding), .resp_err_o(f_resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    m_req    = req;
    s_gnt    = gnt;
    s_rvalid = rv;
    s_rdata  = rd;
  endtask

  task automatic push_rsp(input logic [1:0] mask, input logic [31:0] data);
    exp_rmask.push_back(mask);
    exp_rdata.push_back(data);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or response.
  always @(negedge clk) begin
    if (m_gnt != 2'b00) begin
      if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(m_gnt), 32'h0);
      else chk("gnt", 32'(m_gnt), 32'(exp_gnt.pop_front()));
    end
    if (m_rvalid != 2'b00) begin
      if (exp_rmask.size() == 0) chk("rvalid_unexpected", 32'(m_rvalid), 32'h0);
      else begin
        chk("rvalid_mask", 32'(m_rvalid), 32'(exp_rmask.pop_front()));
        chk("rdata", m_rdata, exp_rdata.pop_front());
      end
    end
    if (f_m_gnt != 2'b00) begin
      if (exp_gnt_f.size() == 0) chk("fixed_gnt_unexpected", 32'(f_m_gnt), 32'h0);
      else chk("fixed_gnt", 32'(f_m_gnt), 32'(exp_gnt_f.pop_front()));
    end
    if (f_m_rvalid != 2'b00) chk("fixed_rvalid_unexpected", 32'(f_m_rvalid), 32'h0);
  end

  initial begin
    rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    f_req = '0; f_gnt = 1'b0;
    m_addr[0] = 32'h0000_0100; m_addr[1] = 32'h2000_0040;
    m_we = 2'b10; m_be[0] = 4'hF; m_be[1] = 4'h3;
    m_wdata[0] = 32'h1111_1111; m_wdata[1] = 32'hCAFE_F00D;

    // Reset cycle: requests present but nothing may leave the arbiter.
    drive(2'b01, 1'b1, 1'b0, '0);
    #1;
    chk("rst_s_req", 32'(s_req), 32'h0);
    chk("rst_outstanding", 32'(outstanding), 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    drive(2'b00, 1'b0, 1'b0, '0);
    rst = 1'b0;

    // Lock: m1 waits ungranted, m0 joins, m1 keeps the bus and is granted first.
    drive(2'b10, 1'b0, 1'b0, '0);
    #1; chk("lock_addr_c1", s_addr, 32'h2000_0040); chk("lock_we_c1", 32'(s_we), 32'h1);
    drive(2'b11, 1'b0, 1'b0, '0);
    #1; chk("lock_addr_c2", s_addr, 32'h2000_0040); chk("lock_req_c2", 32'(s_req), 32'h1);
    drive(2'b11, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b10);
    #1; chk("lock_addr_c3", s_addr, 32'h2000_0040);
    drive(2'b11, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b01);
    #1; chk("lock_addr_c4", s_addr, 32'h0000_0100);
    drive(2'b00, 1'b0, 1'b1, 32'hA000_0001); push_rsp(2'b10, 32'hA000_0001);
    #1; chk("lock_outstanding", 32'(outstanding), 32'h2);
    drive(2'b00, 1'b0, 1'b1, 32'hA000_0002); push_rsp(2'b01, 32'hA000_0002);
    drive(2'b00, 1'b0, 1'b0, '0);
    #1; chk("lock_drained", 32'(outstanding), 32'h0);

    // Single master read.
    drive(2'b01, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b01);
    #1; chk("t1_addr", s_addr, 32'h0000_0100); chk("t1_we", 32'(s_we), 32'h0);
    drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF); push_rsp(2'b01, 32'hDEAD_BEEF);
    #1; chk("t1_count1", 32'(outstanding), 32'h1);
    drive(2'b00, 1'b0, 1'b0, '0);
    #1; chk("t1_count0", 32'(outstanding), 32'h0);

    // Reset so the RR pointer starts at master 0.
    drive(2'b00, 1'b0, 1'b0, '0); rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0, '0); rst = 1'b0;

    // RR contention into full, then release by a single response.
    drive(2'b11, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b01);
    drive(2'b11, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b10);
    drive(2'b11, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b01);
    drive(2'b11, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b10);
    drive(2'b11, 1'b1, 1'b0, '0);
    #1; chk("full_count", 32'(outstanding), 32'h4); chk("full_s_req", 32'(s_req), 32'h0);
    drive(2'b11, 1'b1, 1'b1, 32'hB000_0000); push_rsp(2'b01, 32'hB000_0000);
    #1; chk("full_pop_s_req", 32'(s_req), 32'h0);
    drive(2'b11, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b01);
    #1; chk("after_pop_count", 32'(outstanding), 32'h3); chk("after_pop_s_req", 32'(s_req), 32'h1);
    drive(2'b00, 1'b0, 1'b1, 32'hB000_0001); push_rsp(2'b10, 32'hB000_0001);
    #1; chk("refull_count", 32'(outstanding), 32'h4);
    drive(2'b00, 1'b0, 1'b1, 32'hB000_0002); push_rsp(2'b01, 32'hB000_0002);
    drive(2'b00, 1'b0, 1'b1, 32'hB000_0003); push_rsp(2'b10, 32'hB000_0003);
    drive(2'b00, 1'b0, 1'b1, 32'hB000_0004); push_rsp(2'b01, 32'hB000_0004);
    drive(2'b00, 1'b0, 1'b0, '0);
    #1; chk("t2_drained", 32'(outstanding), 32'h0);

    // Routing m0,m1,m1,m0 with one push+pop overlap.
    drive(2'b01, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b01);
    drive(2'b10, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b10);
    drive(2'b10, 1'b1, 1'b1, 32'hC000_0000); exp_gnt.push_back(2'b10); push_rsp(2'b01, 32'hC000_0000);
    #1; chk("t5_count_a", 32'(outstanding), 32'h2);
    drive(2'b01, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b01);
    #1; chk("t5_pushpop_count", 32'(outstanding), 32'h2);
    drive(2'b00, 1'b0, 1'b1, 32'hC000_0001); push_rsp(2'b10, 32'hC000_0001);
    #1; chk("t5_count_b", 32'(outstanding), 32'h3);
    drive(2'b00, 1'b0, 1'b1, 32'hC000_0002); push_rsp(2'b10, 32'hC000_0002);
    drive(2'b00, 1'b0, 1'b1, 32'hC000_0003); push_rsp(2'b01, 32'hC000_0003);
    drive(2'b00, 1'b0, 1'b0, '0);
    #1; chk("t5_drained", 32'(outstanding), 32'h0);

    // Stray response, then reset with two outstanding.
    drive(2'b00, 1'b0, 1'b1, 32'hBAD0_BAD0);
    #1; chk("stray_rvalid", 32'(m_rvalid), 32'h0);
    drive(2'b00, 1'b0, 1'b0, '0);
    #1; chk("resp_err_set", 32'(resp_err), 32'h1);
    drive(2'b10, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b10);
    drive(2'b10, 1'b1, 1'b0, '0); exp_gnt.push_back(2'b10);
    drive(2'b00, 1'b0, 1'b0, '0);
    #1; chk("pre_rst_count", 32'(outstanding), 32'h2); chk("err_sticky", 32'(resp_err), 32'h1);
    drive(2'b11, 1'b1, 1'b0, '0); rst = 1'b1;
    #1; chk("rst_mid_s_req", 32'(s_req), 32'h0);
    drive(2'b11, 1'b1, 1'b0, '0); rst = 1'b0; exp_gnt.push_back(2'b01);
    #1; chk("post_rst_count", 32'(outstanding), 32'h0); chk("post_rst_err", 32'(resp_err), 32'h0);
    drive(2'b00, 1'b0, 1'b1, 32'hD000_0000); push_rsp(2'b01, 32'hD000_0000);
    drive(2'b00, 1'b0, 1'b0, '0);

    // Fixed priority: master 0 wins every cycle.
    @(posedge clk); #1; f_req = 2'b11; f_gnt = 1'b1; exp_gnt_f.push_back(2'b01);
    @(posedge clk); #1; exp_gnt_f.push_back(2'b01);
    @(posedge clk); #1; exp_gnt_f.push_back(2'b01);
    @(posedge clk); #1; f_req = 2'b00; f_gnt = 1'b0;
    #1; chk("fixed_count", 32'(f_outstanding), 32'h3);

    repeat (2) @(posedge clk);
    #1;
    chk("gnt_queue_left", 32'(exp_gnt.size()), 32'h0);
    chk("rsp_queue_left", 32'(exp_rmask.size()), 32'h0);
    chk("fixed_queue_left", 32'(exp_gnt_f.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
